// File: rtl/vscpu_pkg.sv
// Shared constants and loader state encoding for the vscpu boot path.
package vscpu_pkg;

    localparam int ADDR_LEN_DEFAULT = 14;
    localparam int HDR_W            = 16;

    typedef enum logic [2:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } loader_state_e;

endpackage

// File: rtl/loader_word_packer.sv
// Packs accepted bytes MSB-first into a 32-bit word; word_valid_o flags the 4th byte of a word.
module loader_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  byte_idx_q;
    logic [31:0] shift_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx_q <= 2'd0;
            shift_q    <= 32'd0;
        end else if (clear_i) begin
            byte_idx_q <= 2'd0;
            shift_q    <= 32'd0;
        end else if (byte_valid_i) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            shift_q    <= {shift_q[23:0], byte_i};
        end
    end

    // The full word is held in shift_q from the cycle after the 4th byte onward.
    assign word_valid_o = byte_valid_i & (byte_idx_q == 2'd3);
    assign word_o       = shift_q;

endmodule

// File: rtl/program_loader.sv
// Boot loader: streams a length-prefixed program into RAM, then releases the CPU and hands it the RAM port.
// Optional trailing XOR checksum byte is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import vscpu_pkg::*;
#(
    parameter int ADDR_LEN = ADDR_LEN_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic                reload,
    output logic                cpu_rst,
    input  logic                cpu_wrEn,
    input  logic [ADDR_LEN-1:0] cpu_addr,
    input  logic [31:0]         cpu_data,
    output logic                ram_wrEn,
    output logic [ADDR_LEN-1:0] ram_addr,
    output logic [31:0]         ram_data,
    output logic                load_done,
    output logic                load_err,
    output logic [ADDR_LEN:0]   words_loaded
);

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_LEN;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam loader_state_e S_FINAL = S_CSUM;
`else
    localparam loader_state_e S_FINAL = S_DONE;
`endif

    loader_state_e     state_q, state_d;
    logic [HDR_W-1:0]  n_q, n_d;
    logic [ADDR_LEN:0] widx_q, widx_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              accept;
    logic              word_valid;
    logic [31:0]       word;
    logic [HDR_W-1:0]  hdr_n;
    logic              last_word;

    assign accept    = rx_valid & rx_ready;
    assign hdr_n     = {n_q[HDR_W-1:8], rx_data};
    assign last_word = (32'(widx_q) + 32'd1) == 32'(n_q);

    loader_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (state_q == S_HDR_HI),
        .byte_valid_i (accept && (state_q == S_DATA)),
        .byte_i       (rx_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_HDR_HI;
            n_q     <= '0;
            widx_q  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            widx_q  <= widx_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // rx_ready is gated by rst so the stream is never acknowledged while reset is held.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        widx_d    = widx_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        rx_ready  = 1'b0;
        cpu_rst   = 1'b1;
        ram_wrEn  = 1'b0;
        ram_addr  = '0;
        ram_data  = 32'd0;
        load_done = 1'b0;
        load_err  = 1'b0;

        case (state_q)
            S_HDR_HI: begin
                rx_ready = rst;
                widx_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                csum_d   = 8'd0;
`endif
                if (accept) begin
                    n_d[HDR_W-1:8] = rx_data;
                    state_d        = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                rx_ready = rst;
                if (accept) begin
                    n_d = hdr_n;
                    if (hdr_n == '0)
                        state_d = S_FINAL;
                    else if (32'(hdr_n) > DEPTH)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                rx_ready = rst;
                if (accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (word_valid)
                        state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                ram_wrEn = 1'b1;
                ram_addr = widx_q[ADDR_LEN-1:0];
                ram_data = word;
                widx_d   = widx_q + {{ADDR_LEN{1'b0}}, 1'b1};
                state_d  = last_word ? S_FINAL : S_DATA;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                rx_ready = rst;
                if (accept)
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: begin
                cpu_rst   = 1'b0;
                load_done = 1'b1;
                ram_wrEn  = cpu_wrEn;
                ram_addr  = cpu_addr;
                ram_data  = cpu_data;
                if (reload) begin
                    state_d = S_HDR_HI;
                    widx_d  = '0;
                end
            end
            S_ERR: begin
                load_err = 1'b1;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    assign words_loaded = widx_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed corner sequences, a DONE-state vector table
// and randomized loads compared against a byte-list reference model.
module tb_program_loader;

    localparam int AL = 14;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic            reload;
    logic            cpu_rst;
    logic            cpu_wrEn;
    logic [AL-1:0]   cpu_addr;
    logic [31:0]     cpu_data;
    logic            ram_wrEn;
    logic [AL-1:0]   ram_addr;
    logic [31:0]     ram_data;
    logic            load_done;
    logic            load_err;
    logic [AL:0]     words_loaded;

    int              checks   = 0;
    int              failures = 0;
    bit              noise    = 1'b0;
    logic [7:0]      stream[$];
    logic [7:0]      payload[$];
    int              logAddr[$];
    logic [31:0]     logData[$];

    typedef struct {
        logic          wr;
        logic [AL-1:0] addr;
        logic [31:0]   data;
        logic          expWr;
        logic [AL-1:0] expAddr;
        logic [31:0]   expData;
        logic          expCpuRst;
        logic          expReady;
    } doneVec_t;

    doneVec_t doneTab[4];

    program_loader #(.ADDR_LEN(AL)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .reload       (reload),
        .cpu_rst      (cpu_rst),
        .cpu_wrEn     (cpu_wrEn),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .ram_wrEn     (ram_wrEn),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: every write the DUT commits is logged in order.
    always @(posedge clk) begin
        if (rst && ram_wrEn) begin
            logAddr.push_back(int'(ram_addr));
            logData.push_back(ram_data);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gapMin, input int gapMax);
        int gaps;
        int waitCnt;
        gaps = int'($urandom_range(gapMax, gapMin));
        for (int g = 0; g < gaps; g++) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        if (noise) begin
            reload   = 1'($urandom);
            cpu_wrEn = 1'($urandom);
            cpu_addr = AL'($urandom);
            cpu_data = $urandom;
        end
        waitCnt = 0;
        #1;
        while (!rx_ready && waitCnt < 50) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        if (!rx_ready) checkOutput("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        reload   = 1'b0;
        cpu_wrEn = 1'b0;
    endtask

    task automatic sendRange(input int from, input int upto, input int gapMin, input int gapMax);
        for (int i = from; i < upto; i++) applyStimulus(stream[i], gapMin, gapMax);
    endtask

    task automatic makeStream(input int n);
        logic [7:0] x;
        x = 8'd0;
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        foreach (payload[i]) begin
            stream.push_back(payload[i]);
            x ^= payload[i];
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        stream.push_back(x);
`endif
    endtask

    task automatic waitFinish();
        int c;
        c = 0;
        #1;
        while (!(load_done || load_err) && c < 40) begin
            @(negedge clk);
            #1;
            c++;
        end
    endtask

    // Reference model: word i is payload bytes 4i..4i+3 concatenated MSB-first, written to address i.
    task automatic verifyLoad(input string tag, input int n);
        checkOutput({tag, "_done"}, 32'(load_done), 32'd1);
        checkOutput({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
        checkOutput({tag, "_words"}, 32'(words_loaded), 32'(n));
        checkOutput({tag, "_wr_count"}, 32'(logAddr.size()), 32'(n));
        for (int i = 0; i < n && i < logAddr.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), 32'(logAddr[i]), 32'(i));
            checkOutput($sformatf("%s_word%0d", tag, i), logData[i],
                        {payload[4*i], payload[4*i+1], payload[4*i+2], payload[4*i+3]});
        end
    endtask

    task automatic doReset(input string tag);
        cpu_wrEn = 1'b1;
        cpu_addr = '1;
        cpu_data = 32'hFFFF_FFFF;
        rx_valid = 1'b1;
        rst      = 1'b0;
        #1;
        checkOutput({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        checkOutput({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        checkOutput({tag, "_ram_wrEn"}, 32'(ram_wrEn), 32'd0);
        checkOutput({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        checkOutput({tag, "_ram_data"}, ram_data, 32'd0);
        checkOutput({tag, "_load_done"}, 32'(load_done), 32'd0);
        checkOutput({tag, "_load_err"}, 32'(load_err), 32'd0);
        checkOutput({tag, "_words"}, 32'(words_loaded), 32'd0);
        cpu_wrEn = 1'b0;
        cpu_addr = '0;
        cpu_data = 32'd0;
        rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        logAddr.delete();
        logData.delete();
    endtask

    task automatic doReload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        logAddr.delete();
        logData.delete();
    endtask

    initial begin
        rst      = 1'b0;
        rx_data  = 8'd0;
        rx_valid = 1'b0;
        reload   = 1'b0;
        cpu_wrEn = 1'b0;
        cpu_addr = '0;
        cpu_data = 32'd0;

        doneTab[0] = '{1'b1, 14'h0000, 32'h0000_0001, 1'b1, 14'h0000, 32'h0000_0001, 1'b0, 1'b0};
        doneTab[1] = '{1'b0, 14'h3FFF, 32'hFFFF_FFFF, 1'b0, 14'h3FFF, 32'hFFFF_FFFF, 1'b0, 1'b0};
        doneTab[2] = '{1'b1, 14'h2AAA, 32'hA5A5_5A5A, 1'b1, 14'h2AAA, 32'hA5A5_5A5A, 1'b0, 1'b0};
        doneTab[3] = '{1'b0, 14'h1555, 32'h0000_0000, 1'b0, 14'h1555, 32'h0000_0000, 1'b0, 1'b0};

        @(negedge clk);
        doReset("reset");

        // Reset in the middle of a word, then a fresh load with rx_valid toggling every cycle.
        payload = {8'hAA, 8'hBB};
        makeStream(1);
        sendRange(0, 4, 0, 0);
        doReset("reset_mid");
        payload = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        makeStream(1);
        sendRange(0, 6, 1, 1);
        #1;
        checkOutput("write_wrEn", 32'(ram_wrEn), 32'd1);
        checkOutput("write_addr", 32'(ram_addr), 32'd0);
        checkOutput("write_data", ram_data, 32'hAABB_CCDD);
        checkOutput("write_rx_ready", 32'(rx_ready), 32'd0);
        sendRange(6, stream.size(), 1, 1);
        waitFinish();
        verifyLoad("toggle", 1);

        // Two-word example load, then the DONE-state passthrough table.
        doReset("pre_n2");
        payload = {8'h10, 8'h00, 8'h40, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07};
        makeStream(2);
        sendRange(0, stream.size(), 0, 0);
        waitFinish();
        verifyLoad("n2", 2);
        if (logData.size() == 2) begin
            checkOutput("n2_ram0", logData[0], 32'h1000_4005);
            checkOutput("n2_ram1", logData[1], 32'h0000_0007);
        end

        foreach (doneTab[i]) begin
            cpu_wrEn = doneTab[i].wr;
            cpu_addr = doneTab[i].addr;
            cpu_data = doneTab[i].data;
            #1;
            checkOutput($sformatf("done%0d_wrEn", i), 32'(ram_wrEn), 32'(doneTab[i].expWr));
            checkOutput($sformatf("done%0d_addr", i), 32'(ram_addr), 32'(doneTab[i].expAddr));
            checkOutput($sformatf("done%0d_data", i), ram_data, doneTab[i].expData);
            checkOutput($sformatf("done%0d_cpu_rst", i), 32'(cpu_rst), 32'(doneTab[i].expCpuRst));
            checkOutput($sformatf("done%0d_rx_ready", i), 32'(rx_ready), 32'(doneTab[i].expReady));
            @(negedge clk);
        end
        cpu_wrEn = 1'b0;
        logAddr.delete();
        logData.delete();

        // Reload cycle: the CPU still owns RAM, then the loader takes over.
        reload   = 1'b1;
        cpu_wrEn = 1'b1;
        cpu_addr = 14'd5;
        cpu_data = 32'd9;
        #1;
        checkOutput("reload_cycle_wrEn", 32'(ram_wrEn), 32'd1);
        checkOutput("reload_cycle_cpu_rst", 32'(cpu_rst), 32'd0);
        @(negedge clk);
        reload   = 1'b0;
        cpu_wrEn = 1'b0;
        #1;
        checkOutput("reload_wr_count", 32'(logAddr.size()), 32'd1);
        if (logAddr.size() == 1) begin
            checkOutput("reload_wr_addr", 32'(logAddr[0]), 32'd5);
            checkOutput("reload_wr_data", logData[0], 32'd9);
        end
        checkOutput("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("reload_rx_ready", 32'(rx_ready), 32'd1);
        checkOutput("reload_done", 32'(load_done), 32'd0);
        checkOutput("reload_words", 32'(words_loaded), 32'd0);
        logAddr.delete();
        logData.delete();

        // Empty program.
        payload.delete();
        makeStream(0);
        sendRange(0, stream.size(), 0, 0);
        waitFinish();
        verifyLoad("n0", 0);

        // Randomized loads with stalls, ignored reload pulses and CPU-port noise.
        for (int k = 0; k < 8; k++) begin
            int n;
            doReload();
            n = int'($urandom_range(20, 0));
            payload.delete();
            for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom));
            makeStream(n);
            noise = 1'b1;
            sendRange(0, stream.size(), 0, 2);
            noise = 1'b0;
            waitFinish();
            verifyLoad($sformatf("rand%0d", k), n);
        end

        // N equal to the RAM depth is accepted.
        doReset("pre_full");
        stream = {8'h40, 8'h00};
        sendRange(0, 2, 0, 0);
        #1;
        checkOutput("full_err", 32'(load_err), 32'd0);
        checkOutput("full_rx_ready", 32'(rx_ready), 32'd1);

        // N one past the RAM depth is rejected and the loader stays put.
        doReset("pre_err");
        stream = {8'h40, 8'h01};
        sendRange(0, 2, 0, 0);
        #1;
        checkOutput("err_flag", 32'(load_err), 32'd1);
        checkOutput("err_cpu_rst", 32'(cpu_rst), 32'd1);
        rx_valid = 1'b1;
        reload   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("err_hold%0d_rx_ready", i), 32'(rx_ready), 32'd0);
            checkOutput($sformatf("err_hold%0d_err", i), 32'(load_err), 32'd1);
            checkOutput($sformatf("err_hold%0d_wrEn", i), 32'(ram_wrEn), 32'd0);
        end
        rx_valid = 1'b0;
        reload   = 1'b0;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        doReset("pre_cs_ok");
        stream = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        sendRange(0, stream.size(), 0, 0);
        waitFinish();
        checkOutput("cs_ok_done", 32'(load_done), 32'd1);
        checkOutput("cs_ok_err", 32'(load_err), 32'd0);

        doReset("pre_cs_bad");
        stream = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        sendRange(0, stream.size(), 0, 0);
        waitFinish();
        checkOutput("cs_bad_err", 32'(load_err), 32'd1);
        checkOutput("cs_bad_done", 32'(load_done), 32'd0);
        checkOutput("cs_bad_wr_count", 32'(logAddr.size()), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
